// File: rtl/operand_fwd_unit_pkg.sv
// Shared encodings for the operand forwarding unit: per-channel operand
// source selects and the load-use stall FSM states.
package operand_fwd_unit_pkg;

    typedef enum logic [1:0] {
        SEL_RF   = 2'b00,
        SEL_WB   = 2'b01,
        SEL_MEM  = 2'b10,
        SEL_HOLD = 2'b11
    } fwd_sel_e;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } stall_state_e;

    localparam int CNT_W = 2;

endpackage

// File: rtl/operand_fwd_unit_fwd_channel.sv
// One EX operand channel: MEM/WB/RF bypass select plus a capture register
// that keeps the operand stable while EX is frozen.
module fwd_channel
    import operand_fwd_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs_i,
    input  logic [DATA_W-1:0] rd_i,
    input  logic              regwrite_m_i,
    input  logic [REG_AW-1:0] writereg_m_i,
    input  logic [DATA_W-1:0] aluout_m_i,
    input  logic              regwrite_w_i,
    input  logic [REG_AW-1:0] writereg_w_i,
    input  logic [DATA_W-1:0] result_w_i,
    input  logic              capture_i,
    input  logic              hold_vld_i,
    output logic [DATA_W-1:0] op_o,
    output logic [1:0]        sel_o
);

    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] hold_d;
    logic [DATA_W-1:0] live_val;
    fwd_sel_e          live_sel;
    logic              rs_nonzero;

    // MEM is the younger producer, so it wins over WB; r0 is never bypassed.
    always_comb begin
        rs_nonzero = (rs_i != '0);
        live_sel   = SEL_RF;
        live_val   = rd_i;
        if (rs_nonzero && regwrite_m_i && (writereg_m_i == rs_i)) begin
            live_sel = SEL_MEM;
            live_val = aluout_m_i;
        end else if (rs_nonzero && regwrite_w_i && (writereg_w_i == rs_i)) begin
            live_sel = SEL_WB;
            live_val = result_w_i;
        end
    end

    always_comb begin
        hold_d = hold_q;
        if (capture_i) begin
            hold_d = live_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign op_o  = hold_vld_i ? hold_q : live_val;
    assign sel_o = hold_vld_i ? SEL_HOLD : live_sel;

endmodule

// File: rtl/operand_fwd_unit.sv
// Operand forwarding and load-use hazard unit: per-channel bypass muxes with
// EX-freeze hold, and a counted decode stall after a load-use hit.
module operand_fwd_unit
    import operand_fwd_unit_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int NOPS     = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NOPS*REG_AW-1:0]   rs_e,
    input  logic [NOPS*DATA_W-1:0]   rd_e,
    input  logic                     regwrite_m,
    input  logic [REG_AW-1:0]        writereg_m,
    input  logic [DATA_W-1:0]        aluout_m,
    input  logic                     regwrite_w,
    input  logic [REG_AW-1:0]        writereg_w,
    input  logic [DATA_W-1:0]        result_w,
    input  logic                     memtoreg_e,
    input  logic [REG_AW-1:0]        writereg_e,
    input  logic [NOPS*REG_AW-1:0]   rs_d,
    input  logic                     ex_hold,
    output logic [NOPS*DATA_W-1:0]   op_e,
    output logic [NOPS*2-1:0]        fwd_sel,
    output logic                     stall_d,
    output logic                     flush_e
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_LAT - 1);

    stall_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             hold_vld_q;
    logic             hold_vld_d;
    logic             hold_act;
    logic             capture;
    logic             hit;
    logic             any_src_match;
    logic             stall_act;

    always_comb begin
        any_src_match = 1'b0;
        for (int i = 0; i < NOPS; i++) begin
            if (rs_d[i*REG_AW +: REG_AW] == writereg_e) begin
                any_src_match = 1'b1;
            end
        end
        hit = memtoreg_e && (writereg_e != '0) && any_src_match;
    end

    // Hold is valid exactly on the cycle after a frozen edge, so its next
    // state collapses to ex_hold; the capture happens only on the first one.
    assign hold_vld_d = ex_hold;
    assign capture    = ex_hold && !hold_vld_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_vld_q <= 1'b0;
        end else begin
            hold_vld_q <= hold_vld_d;
        end
    end

    // Registered state is masked during reset so outputs fall back to live.
    assign hold_act = hold_vld_q && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hit && (LOAD_LAT > 1)) begin
                        state_q <= STALL;
                        cnt_q   <= CNT_INIT;
                    end
                end
                STALL: begin
                    if (!ex_hold) begin
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign stall_act = (rst_n && (state_q == STALL)) ? 1'b1 : hit;
    assign stall_d   = stall_act;
    assign flush_e   = stall_act;

    for (genvar g = 0; g < NOPS; g++) begin : g_ch
        fwd_channel #(
            .DATA_W (DATA_W),
            .REG_AW (REG_AW)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .rs_i         (rs_e[g*REG_AW +: REG_AW]),
            .rd_i         (rd_e[g*DATA_W +: DATA_W]),
            .regwrite_m_i (regwrite_m),
            .writereg_m_i (writereg_m),
            .aluout_m_i   (aluout_m),
            .regwrite_w_i (regwrite_w),
            .writereg_w_i (writereg_w),
            .result_w_i   (result_w),
            .capture_i    (capture),
            .hold_vld_i   (hold_act),
            .op_o         (op_e[g*DATA_W +: DATA_W]),
            .sel_o        (fwd_sel[g*2 +: 2])
        );
    end

endmodule

// File: doc/operand_fwd_unit.md
OPERAND_FWD_UNIT -- requirements
Module: operand_fwd_unit

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width in bits.
REQ-002 Parameter REG_AW, default 5, register address width.
REQ-003 Parameter NOPS, default 2, number of EX operands (channels) served.
REQ-004 Parameter LOAD_LAT, default 1, range 1..3, load-use stall length in cycles.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 rs_e  in  NOPS*REG_AW  EX-stage source register per operand; operand i in slice i.
REQ-008 rd_e  in  NOPS*DATA_W  register-file read data per operand.
REQ-009 regwrite_m, writereg_m[REG_AW], aluout_m[DATA_W]  in  MEM-stage write flag, destination, value.
REQ-010 regwrite_w, writereg_w[REG_AW], result_w[DATA_W]  in  WB-stage write flag, destination, value.
REQ-011 memtoreg_e, writereg_e[REG_AW]  in  EX-stage load flag and destination.
REQ-012 rs_d  in  NOPS*REG_AW  decode-stage source registers.
REQ-013 ex_hold  in  1  EX stage frozen by an external stall this cycle.
REQ-014 op_e  out  NOPS*DATA_W  forwarded operand per channel.
REQ-015 fwd_sel  out  NOPS*2  selection per channel: 00 RF, 01 WB, 10 MEM, 11 HOLD.
REQ-016 stall_d  out  1  freeze fetch/decode.
REQ-017 flush_e  out  1  insert bubble into EX.

Function
REQ-018 Per channel, the live selection SHALL be MEM if regwrite_m and writereg_m==rs_e[i] and rs_e[i]!=0; otherwise WB under the same rule; otherwise RF.
REQ-019 Register 0 SHALL never be forwarded; op_e[i] SHALL equal rd_e[i] when rs_e[i]==0.
REQ-020 Each channel SHALL have hold_q[DATA_W] and one shared hold_vld flag.
REQ-021 On each edge with ex_hold=1 and hold_vld=0, hold_q[i] SHALL capture the live selected value; hold_vld SHALL set.
REQ-022 On each edge with ex_hold=0, hold_vld SHALL clear; hold_q SHALL stay unchanged.
REQ-023 While hold_vld=1, op_e[i] SHALL equal hold_q[i] and fwd_sel[i] SHALL equal 11; otherwise op_e/fwd_sel SHALL follow the live selection combinationally (zero latency).
REQ-024 Load-use hit SHALL be memtoreg_e=1, writereg_e!=0, and writereg_e equal to any rs_d[i].
REQ-025 FSM states: IDLE, STALL; counter cnt of width 2.
REQ-026 In IDLE, stall_d=flush_e=hit combinationally; on hit with LOAD_LAT>1, move to STALL with cnt=LOAD_LAT-1.
REQ-027 In STALL, stall_d=flush_e=1; cnt SHALL decrement each edge with ex_hold=0; on the edge where cnt==1 and ex_hold=0, return to IDLE.
REQ-028 With ex_hold=1 in STALL, cnt SHALL freeze; the state SHALL remain STALL.
REQ-029 With LOAD_LAT=1, the FSM SHALL never leave IDLE.
REQ-030 In STALL, new hits SHALL be ignored; re-detection SHALL occur in IDLE.

Reset
REQ-031 On an edge with rst_n=0: state=IDLE, cnt=0, hold_vld=0, hold_q=0; this SHALL abort any STALL or HOLD in progress.
REQ-032 While in reset, outputs SHALL follow the combinational rules with hold_vld=0: stall_d=flush_e=hit, op_e=live selection.

Structure
REQ-033 A shared package SHALL hold the fwd_sel encodings (SEL_RF, SEL_WB, SEL_MEM, SEL_HOLD) and FSM state encodings.
REQ-034 The per-channel select and hold logic SHALL be one sub-module, fwd_channel, instantiated NOPS times by generate.

Verification
REQ-035 rs_e[0]=3; regwrite_m=1, writereg_m=3, aluout_m=0xAAAA0000; regwrite_w=1, writereg_w=3, result_w=0x5555 -> op_e[0]=0xAAAA0000, fwd_sel[0]=10.
REQ-036 rs_e[1]=0; M and W both write reg 0 -> op_e[1]=rd_e[1], fwd_sel[1]=00.
REQ-037 ex_hold=1 for 2 cycles, W value 0x1234 forwarded in cycle 0, then W changes -> op_e=0x1234 in cycles 1-2, fwd_sel=11; live in cycle 3.
REQ-038 LOAD_LAT=3, memtoreg_e=1, writereg_e=7, rs_d[1]=7 -> stall_d=flush_e=1 for exactly 3 cycles.
REQ-039 LOAD_LAT=3 stall with ex_hold=1 for 2 cycles mid-stall -> stall_d held 5 cycles total.
REQ-040 rst_n=0 for one cycle during STALL with hold_vld=1 -> next cycle IDLE, stall_d=0 when no hit, hold_vld=0.
